control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ir  in  32  instruction register contents from the datapath.
REQ-005 zero  in  1  ALU zero flag from the datapath.
REQ-006 busy  in  1  memory not ready; holds memory states.
REQ-007 ALUControl  out  4  ALU operation.
REQ-008 lda, ldb, ldma, ldiR  out  1 each  load A, B, memory-address, instruction registers from the bus.
REQ-009 reg_sel  out  2  register-file index select: 00=rs1, 01=rs2, 10=rd.
REQ-010 reg_en, mem_en, alu_en, IMM_en, pc_en  out  1 each  bus drive / access enables.
REQ-011 reg_we, mem_we  out  1 each  register-file write, memory write.
REQ-012 ExtendSign_sel  out  2  immediate format: 00=I, 01=S, 10=B.
REQ-013 pc  out  32  current PC, driven onto the bus when pc_en=1.
REQ-014 instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-015 illegal  out  1  sticky unsupported-opcode flag.
REQ-016 state  out  4  current FSM state (debug).

Function
REQ-017 The FSM SHALL be Moore, with states FETCH_A, FETCH_B, DECODE, REG_A, REG_B, EXEC, WB, MEM_RD, MEM_WR, ILLEGAL; outputs not listed for a state are 0.
REQ-018 FETCH_A: pc_en=1, ldma=1; next FETCH_B.
REQ-019 FETCH_B: mem_en=1; while busy=1 stay; when busy=0 assert ldiR=1 and go to DECODE.
REQ-020 DECODE: no enables; opcode 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW), 1100011 with funct3=000 (BEQ) -> REG_A; any other -> ILLEGAL.
REQ-021 REG_A: reg_en=1, reg_sel=00, lda=1.
REQ-022 REG_B: R/BEQ: reg_en=1, reg_sel=01, ldb=1; I/LW: IMM_en=1, ExtendSign_sel=00, ldb=1; SW: IMM_en=1, ExtendSign_sel=01, ldb=1.
REQ-023 EXEC: alu_en=1; R/I -> WB; LW -> MEM_RD and SW -> MEM_WR, both with ldma=1 and ALUControl=ADD; BEQ is final (ALUControl=SUB).
REQ-024 ALUControl: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 0111 SLT; funct3 000->ADD (SUB when R and funct7[5]=1), 111->AND, 110->OR, 100->XOR, 010->SLT; other funct3 -> ILLEGAL from DECODE.
REQ-025 WB: alu_en=1, reg_sel=10, reg_we=1; final.
REQ-026 MEM_RD: mem_en=1, reg_sel=10; stay while busy=1; reg_we=1 only in the cycle busy=0, which is final.
REQ-027 MEM_WR: mem_en=1, mem_we=1, reg_en=1, reg_sel=01; stay while busy=1; final when busy=0.
REQ-028 Bus drivers SHALL be one-hot: at most one of reg_en, alu_en, IMM_en, pc_en, or (mem_en with mem_we=0) per cycle.
REQ-029 In each final cycle instr_done=1 and PC updates: pc+4, except BEQ with zero=1 -> pc + sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}); 32-bit wrap-around, no overflow detection.
REQ-030 Next state after any final cycle SHALL be FETCH_A.
REQ-031 Latency with busy=0: R/I/LW/SW 7 cycles, BEQ 6 cycles; each busy=1 cycle adds one.
REQ-032 ILLEGAL: absorbing state, illegal=1, all controls 0, PC frozen, until rst.

Reset
REQ-033 When rst=1 at a clock edge: state<=FETCH_A, pc<=RESET_PC, illegal<=0, regardless of current state, including mid-access with busy=1.
REQ-034 While rst=1 all control outputs and instr_done SHALL be forced to 0; FETCH_A outputs appear the first cycle after deassertion.

Verification
REQ-035 Reset then ir=0x002081B3 (add x3,x1,x2), busy=0 -> FETCH_A..WB in 7 cycles, ALUControl=0010 in EXEC, reg_we=1 reg_sel=10 in WB, pc 0->4.
REQ-036 ir=0x40208133 (sub) -> ALUControl=0110 in EXEC; ir=0x00A0A093 (slti) -> ALUControl=0111, IMM_en=1 ExtendSign_sel=00 in REG_B.
REQ-037 LW ir=0x0040A183 with busy=1 for 3 cycles in MEM_RD -> reg_we only in 4th MEM_RD cycle, instruction takes 10 cycles, pc+=4.
REQ-038 BEQ ir=0x00208463 at pc=0x10: zero=1 in EXEC -> pc=0x18; zero=0 -> pc=0x14; 6 cycles, no reg_we.
REQ-039 ir=0x0000007F -> ILLEGAL after DECODE, illegal=1 and pc constant for 20 cycles; rst=1 -> FETCH_A, illegal=0, pc=RESET_PC.
REQ-040 Every cycle of all scenarios: bus one-hot rule of REQ-028 holds; rst asserted in MEM_WR with busy=1 -> next cycle FETCH_A, mem_we=0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle sequencer for a small RV32 subset: R-type ALU, I-type ALU,
//   LW, SW and BEQ. A Moore FSM steers a single shared bus in the datapath
//   (exactly one bus driver per cycle) and owns the program counter.
//
// Ports
//   clk, rst          sole clock; synchronous active-high reset
//   ir                instruction register contents from the datapath
//   zero              ALU zero flag (sampled in EXEC of a BEQ)
//   busy              memory not ready; stretches FETCH_B, MEM_RD, MEM_WR
//   ALUControl        ALU operation code
//   lda/ldb/ldma/ldiR load A, B, memory-address, instruction registers
//   reg_sel           register-file index: 00=rs1, 01=rs2, 10=rd
//   reg_en/mem_en/alu_en/IMM_en/pc_en   bus drive and access enables
//   reg_we/mem_we     register-file write, memory write
//   ExtendSign_sel    immediate format: 00=I, 01=S, 10=B
//   pc                current program counter
//   instr_done        pulse in the final cycle of each instruction
//   illegal           sticky unsupported-instruction flag
//   state             current FSM state (debug)

module control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        zero,
  input  logic        busy,
  output logic [3:0]  ALUControl,
  output logic        lda,
  output logic        ldb,
  output logic        ldma,
  output logic        ldiR,
  output logic [1:0]  reg_sel,
  output logic        reg_en,
  output logic        mem_en,
  output logic        alu_en,
  output logic        IMM_en,
  output logic        pc_en,
  output logic        reg_we,
  output logic        mem_we,
  output logic [1:0]  ExtendSign_sel,
  output logic [31:0] pc,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH_A = 4'd0,
    S_FETCH_B = 4'd1,
    S_DECODE  = 4'd2,
    S_REG_A   = 4'd3,
    S_REG_B   = 4'd4,
    S_EXEC    = 4'd5,
    S_WB      = 4'd6,
    S_MEM_RD  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_t;

  typedef enum logic [2:0] {
    OP_R,
    OP_I,
    OP_LW,
    OP_SW,
    OP_BEQ,
    OP_BAD
  } op_class_t;

  localparam logic [1:0] SEL_RS1 = 2'b00;
  localparam logic [1:0] SEL_RS2 = 2'b01;
  localparam logic [1:0] SEL_RD  = 2'b10;
  localparam logic [1:0] EXT_I   = 2'b00;
  localparam logic [1:0] EXT_S   = 2'b01;

  state_t    state_q, state_d;
  op_class_t op_class;
  alu_op_t   alu_op;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct3_ok;
  logic [31:0] branch_target;
  logic [31:0] pc_next;

  // Register-number fields are consumed by the datapath, not by the sequencer.
  logic unused_ir;
  assign unused_ir = ^ir[24:15];

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign state  = state_q;

  // ---------------------------------------------------------------------------
  // Instruction decode (ir is stable from DECODE until the instruction ends)
  // ---------------------------------------------------------------------------
  always_comb begin
    funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                (funct3 == 3'b100) || (funct3 == 3'b010);
    case (opcode)
      7'b0110011: op_class = funct3_ok ? OP_R : OP_BAD;
      7'b0010011: op_class = funct3_ok ? OP_I : OP_BAD;
      7'b0000011: op_class = OP_LW;
      7'b0100011: op_class = OP_SW;
      7'b1100011: op_class = (funct3 == 3'b000) ? OP_BEQ : OP_BAD;
      default:    op_class = OP_BAD;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  alu_op = (op_class == OP_R && ir[30]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end

  // B-type offset is 13 bits with an implicit zero LSB, sign-extended to 32.
  assign branch_target = pc + {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  // Only a BEQ finishes in EXEC, so a taken branch is decided there.
  assign pc_next = (state_q == S_EXEC && op_class == OP_BEQ && zero) ? branch_target
                                                                      : pc + 32'd4;

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    state_d        = state_q;
    ALUControl     = 4'b0000;
    lda            = 1'b0;
    ldb            = 1'b0;
    ldma           = 1'b0;
    ldiR           = 1'b0;
    reg_sel        = SEL_RS1;
    reg_en         = 1'b0;
    mem_en         = 1'b0;
    alu_en         = 1'b0;
    IMM_en         = 1'b0;
    pc_en          = 1'b0;
    reg_we         = 1'b0;
    mem_we         = 1'b0;
    ExtendSign_sel = EXT_I;
    instr_done     = 1'b0;

    // Holding rst silences every control, even mid-access with busy=1.
    if (!rst) begin
      case (state_q)
        S_FETCH_A: begin
          pc_en   = 1'b1;
          ldma    = 1'b1;
          state_d = S_FETCH_B;
        end
        S_FETCH_B: begin
          mem_en = 1'b1;
          if (!busy) begin
            ldiR    = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          state_d = (op_class == OP_BAD) ? S_ILLEGAL : S_REG_A;
        end
        S_REG_A: begin
          reg_en  = 1'b1;
          reg_sel = SEL_RS1;
          lda     = 1'b1;
          state_d = S_REG_B;
        end
        S_REG_B: begin
          ldb     = 1'b1;
          state_d = S_EXEC;
          case (op_class)
            OP_R, OP_BEQ: begin
              reg_en  = 1'b1;
              reg_sel = SEL_RS2;
            end
            OP_SW: begin
              IMM_en         = 1'b1;
              ExtendSign_sel = EXT_S;
            end
            default: begin
              IMM_en         = 1'b1;
              ExtendSign_sel = EXT_I;
            end
          endcase
        end
        S_EXEC: begin
          alu_en = 1'b1;
          case (op_class)
            OP_LW: begin
              ALUControl = ALU_ADD;
              ldma       = 1'b1;
              state_d    = S_MEM_RD;
            end
            OP_SW: begin
              ALUControl = ALU_ADD;
              ldma       = 1'b1;
              state_d    = S_MEM_WR;
            end
            OP_BEQ: begin
              ALUControl = ALU_SUB;
              instr_done = 1'b1;
              state_d    = S_FETCH_A;
            end
            default: begin
              ALUControl = alu_op;
              state_d    = S_WB;
            end
          endcase
        end
        S_WB: begin
          alu_en     = 1'b1;
          reg_sel    = SEL_RD;
          reg_we     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH_A;
        end
        S_MEM_RD: begin
          mem_en  = 1'b1;
          reg_sel = SEL_RD;
          if (!busy) begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH_A;
          end
        end
        S_MEM_WR: begin
          mem_en  = 1'b1;
          mem_we  = 1'b1;
          reg_en  = 1'b1;
          reg_sel = SEL_RS2;
          if (!busy) begin
            instr_done = 1'b1;
            state_d    = S_FETCH_A;
          end
        end
        S_ILLEGAL: begin
          state_d = S_ILLEGAL;
        end
        default: begin
          state_d = S_FETCH_A;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, PC and sticky illegal flag
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH_A;
      pc      <= RESET_PC;
      illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_done) begin
        pc <= pc_next;
      end
      if (state_d == S_ILLEGAL) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule
